hdmi_timing_gen: RTL and testbench



---
 rtl/hdmi_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator for the HDMI output path: DE/HSYNC/VSYNC strobes,
// pixel coordinates, line/frame pulses and a completed-frame counter.
module hdmi_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk_hdmi,
   input  logic        rst,
   input  logic        enable,
   output logic        HDMI_DE,
   output logic        HDMI_HSYNC,
   output logic        HDMI_VSYNC,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count,
   output logic        running,
   output logic [1:0]  state_dbg
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_ACT_L  = 12'(H_ACTIVE);
   localparam logic [11:0] H_HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_L  = 12'(V_ACTIVE);
   localparam logic [11:0] V_VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      s_IDLE = 2'd0,
      s_RUN  = 2'd1,
      s_STOP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        en_meta;
   logic        en_s;
   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic        advance;
   logic        h_last;
   logic        v_last;

   logic        de_d;
   logic        hs_n_d;
   logic        vs_n_d;
   logic        ls_d;
   logic        fs_d;
   logic [11:0] x_d;
   logic [11:0] y_d;

   // enable comes from the clk_cpu side; en_s is the only copy the FSM sees
   always_ff @(posedge clk_hdmi or posedge rst) begin
      if (rst) begin
         en_meta <= 1'b0;
         en_s    <= 1'b0;
      end else begin
         en_meta <= enable;
         en_s    <= en_meta;
      end
   end

   assign advance = (state != s_IDLE);
   assign h_last  = (h_cnt == H_LAST);
   assign v_last  = (v_cnt == V_LAST);

   always_ff @(posedge clk_hdmi or posedge rst) begin
      if (rst) begin
         state <= s_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Stop requests only land on the frame boundary, so frames are never cut short
   always_comb begin
      state_next = state;
      case (state)
         s_IDLE:  if (en_s) state_next = s_RUN;
         s_RUN:   if (!en_s) state_next = s_STOP;
         s_STOP: begin
            if (en_s)                 state_next = s_RUN;
            else if (h_last && v_last) state_next = s_IDLE;
         end
         default: state_next = s_IDLE;
      endcase
   end

   always_ff @(posedge clk_hdmi or posedge rst) begin
      if (rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_count <= '0;
      end else if (!advance) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         if (v_last) begin
            v_cnt       <= '0;
            frame_count <= frame_count + 16'd1;
         end else begin
            v_cnt <= v_cnt + 12'd1;
         end
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // Idle values are presented both while idle and on the edge that enters idle
   always_comb begin
      de_d   = 1'b0;
      hs_n_d = 1'b1;
      vs_n_d = 1'b1;
      ls_d   = 1'b0;
      fs_d   = 1'b0;
      x_d    = '0;
      y_d    = '0;
      if (advance && (state_next != s_IDLE)) begin
         de_d   = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
         hs_n_d = !((h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END));
         vs_n_d = !((v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END));
         ls_d   = (h_cnt == 12'd0);
         fs_d   = (h_cnt == 12'd0) && (v_cnt == 12'd0);
         x_d    = h_cnt;
         y_d    = v_cnt;
      end
   end

   always_ff @(posedge clk_hdmi or posedge rst) begin
      if (rst) begin
         HDMI_DE     <= 1'b0;
         HDMI_HSYNC  <= 1'b1;
         HDMI_VSYNC  <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
      end else begin
         HDMI_DE     <= de_d;
         HDMI_HSYNC  <= hs_n_d;
         HDMI_VSYNC  <= vs_n_d;
         line_start  <= ls_d;
         frame_start <= fs_d;
         pix_x       <= x_d;
         pix_y       <= y_d;
      end
   end

   assign running   = (state == s_RUN) || (state == s_STOP);
   assign state_dbg = state;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen using the small raster 4/1/2/1 x 3/1/1/1
// (8 clks per line, 6 lines, 48 clks per frame).
module tb_hdmi_timing_gen;

   logic        clk_hdmi;
   logic        rst;
   logic        enable;
   logic        HDMI_DE;
   logic        HDMI_HSYNC;
   logic        HDMI_VSYNC;
   logic [11:0] pix_x;
   logic [11:0] pix_y;
   logic        line_start;
   logic        frame_start;
   logic [15:0] frame_count;
   logic        running;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   hdmi_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut (
      .clk_hdmi   (clk_hdmi),
      .rst        (rst),
      .enable     (enable),
      .HDMI_DE    (HDMI_DE),
      .HDMI_HSYNC (HDMI_HSYNC),
      .HDMI_VSYNC (HDMI_VSYNC),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .line_start (line_start),
      .frame_start(frame_start),
      .frame_count(frame_count),
      .running    (running),
      .state_dbg  (state_dbg)
   );

   // clock / reset block
   initial clk_hdmi = 1'b0;
   always #5 clk_hdmi = ~clk_hdmi;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one active edge, then settle at the following falling edge
   task automatic step();
      @(posedge clk_hdmi);
      @(negedge clk_hdmi);
   endtask

   task automatic check_idle(input string tag, input logic [15:0] fc);
      check_eq({tag, "_de"},  HDMI_DE, 0);
      check_eq({tag, "_hs"},  HDMI_HSYNC, 1);
      check_eq({tag, "_vs"},  HDMI_VSYNC, 1);
      check_eq({tag, "_x"},   pix_x, 0);
      check_eq({tag, "_y"},   pix_y, 0);
      check_eq({tag, "_ls"},  line_start, 0);
      check_eq({tag, "_fs"},  frame_start, 0);
      check_eq({tag, "_run"}, running, 0);
      check_eq({tag, "_fc"},  frame_count, fc);
   endtask

   initial begin
      int de_cnt;
      int hs_cnt;
      int vs_cnt;
      int h;
      int v;
      bit run_ok;

      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk_hdmi);
      check_idle("reset", 16'd0);
      check_eq("reset_state", state_dbg, 0);

      // startup: edge 0, then enable sampled at edge 1
      rst = 1'b0;
      step();
      enable = 1'b1;
      step();
      step();
      check_eq("start_e2_run", running, 0);
      step();
      check_eq("start_e3_run", running, 1);
      check_eq("start_e3_state", state_dbg, 1);
      check_eq("start_e3_de", HDMI_DE, 0);
      step();
      check_eq("start_e4_de", HDMI_DE, 1);
      check_eq("start_e4_ls", line_start, 1);
      check_eq("start_e4_fs", frame_start, 1);
      check_eq("start_e4_x", pix_x, 0);
      check_eq("start_e4_y", pix_y, 0);

      // one full frame, pixel by pixel
      de_cnt = 1;
      hs_cnt = 0;
      vs_cnt = 0;
      for (int p = 1; p < 48; p++) begin
         step();
         h = p % 8;
         v = p / 8;
         check_eq("frm_x", pix_x, h);
         check_eq("frm_y", pix_y, v);
         check_eq("frm_de", HDMI_DE, (h < 4 && v < 3));
         check_eq("frm_hs", HDMI_HSYNC, !(h == 5 || h == 6));
         check_eq("frm_vs", HDMI_VSYNC, !(v == 4));
         check_eq("frm_ls", line_start, (h == 0));
         check_eq("frm_fs", frame_start, 0);
         check_eq("frm_fc", frame_count, (p == 47) ? 1 : 0);
         if (HDMI_DE) de_cnt++;
         if (!HDMI_HSYNC) hs_cnt++;
         if (!HDMI_VSYNC) vs_cnt++;
      end
      check_eq("frm_de_total", de_cnt, 12);
      check_eq("frm_hs_total", hs_cnt, 12);
      check_eq("frm_vs_total", vs_cnt, 8);

      // second frame starts exactly 48 clks later
      step();
      check_eq("frm2_fs", frame_start, 1);
      check_eq("frm2_x", pix_x, 0);
      check_eq("frm2_y", pix_y, 0);

      // stop request at v=2: frame completes, then idle
      repeat (16) step();
      check_eq("stop_req_x", pix_x, 0);
      check_eq("stop_req_y", pix_y, 2);
      enable = 1'b0;
      step();
      step();
      step();
      check_eq("stop_state", state_dbg, 2);
      repeat (27) step();
      check_eq("stop_last_run", running, 1);
      check_eq("stop_last_x", pix_x, 6);
      check_eq("stop_last_y", pix_y, 5);
      check_eq("stop_last_fc", frame_count, 1);
      step();
      check_idle("stopped", 16'd2);
      check_eq("stopped_state", state_dbg, 0);
      repeat (5) step();
      check_idle("still_idle", 16'd2);

      // restart, then a short deassert that must not open a gap
      enable = 1'b1;
      repeat (4) step();
      check_eq("restart_fs", frame_start, 1);
      check_eq("restart_de", HDMI_DE, 1);
      run_ok = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         if (k == 24) enable = 1'b0;
         if (k == 30) enable = 1'b1;
         step();
         if (!running) run_ok = 1'b0;
         if (k == 28) check_eq("blip_state", state_dbg, 2);
         if (k == 47) check_eq("blip_fs_early", frame_start, 0);
      end
      check_eq("blip_running", run_ok, 1);
      check_eq("blip_fs", frame_start, 1);
      check_eq("blip_x", pix_x, 0);
      check_eq("blip_y", pix_y, 0);
      check_eq("blip_fc", frame_count, 3);

      // asynchronous reset mid-frame at x=3, y=2
      repeat (19) step();
      check_eq("pre_rst_x", pix_x, 3);
      check_eq("pre_rst_y", pix_y, 2);
      check_eq("pre_rst_de", HDMI_DE, 1);
      #2;
      rst = 1'b1;
      #1;
      check_idle("async_rst", 16'd0);
      @(negedge clk_hdmi);
      rst = 1'b0;
      step();
      step();
      check_eq("rerun_e1_run", running, 0);
      step();
      check_eq("rerun_e2_run", running, 1);
      check_eq("rerun_e2_de", HDMI_DE, 0);
      step();
      check_eq("rerun_e3_de", HDMI_DE, 1);
      check_eq("rerun_e3_fs", frame_start, 1);
      check_eq("rerun_e3_x", pix_x, 0);
      check_eq("rerun_e3_y", pix_y, 0);
      step();
      check_eq("rerun_e4_x", pix_x, 1);
      check_eq("rerun_e4_fs", frame_start, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
